// File: rtl/iigs_shadow_pkg.sv
// Shared constants and entry type for the IIgs shadow writer.
// Region bounds are inclusive CPU addresses within bank 00/01.
package iigs_shadow_pkg;

  localparam logic [15:0] TXT1_LO = 16'h0400;
  localparam logic [15:0] TXT1_HI = 16'h07FF;
  localparam logic [15:0] TXT2_LO = 16'h0800;
  localparam logic [15:0] TXT2_HI = 16'h0BFF;
  localparam logic [15:0] HGR1_LO = 16'h2000;
  localparam logic [15:0] HGR1_HI = 16'h3FFF;
  localparam logic [15:0] HGR2_LO = 16'h4000;
  localparam logic [15:0] HGR2_HI = 16'h5FFF;
  localparam logic [15:0] SHR_LO  = 16'h2000;
  localparam logic [15:0] SHR_HI  = 16'h9FFF;

  localparam int SH_TXT1 = 0;
  localparam int SH_HGR1 = 1;
  localparam int SH_HGR2 = 2;
  localparam int SH_SHR  = 3;
  localparam int SH_AUX  = 4;
  localparam int SH_TXT2 = 5;

  typedef struct packed {
    logic        bank0;
    logic [15:0] addr;
    logic [7:0]  data;
  } shadow_entry_t;

  function automatic logic in_rng(
    input logic [15:0] a,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/shadow_fifo.sv
// Small synchronous FIFO holding pending shadow writes.
// A push while full is taken only when a pop frees a slot that cycle.
module shadow_fifo
  import iigs_shadow_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  shadow_entry_t            din,
  output shadow_entry_t            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  shadow_entry_t    mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shadow_writer.sv
// Mirrors bank 00/01 CPU writes into slow RAM (E0/E1) through a
// small FIFO drained on slow-bus write slots.
module shadow_writer
  import iigs_shadow_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        fast_clk,
  input  logic [7:0]  bank,
  input  logic [15:0] addr,
  input  logic [7:0]  dout,
  input  logic        we,
  input  logic [7:0]  SHADOW,
  input  logic        slow_ce,
  output logic [16:0] shadow_addr,
  output logic [7:0]  shadow_data,
  output logic        shadow_we,
  output logic        cpu_stall,
  output logic        overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          bank_ok;
  logic          aux;
  logic          hit;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  shadow_entry_t entry;
  shadow_entry_t head;

  logic unused_sh;
  assign unused_sh = ^SHADOW[7:6];

  assign bank_ok = (bank[7:1] == 7'd0);
  assign aux     = bank[0];

  // HGR pages in bank 01 are additionally gated by the aux inhibit bit.
  always_comb begin
    hit = 1'b0;
    if (in_rng(addr, TXT1_LO, TXT1_HI) && !SHADOW[SH_TXT1])
      hit = 1'b1;
    if (in_rng(addr, TXT2_LO, TXT2_HI) && !SHADOW[SH_TXT2])
      hit = 1'b1;
    if (in_rng(addr, HGR1_LO, HGR1_HI) && !SHADOW[SH_HGR1]
        && !(aux && SHADOW[SH_AUX]))
      hit = 1'b1;
    if (in_rng(addr, HGR2_LO, HGR2_HI) && !SHADOW[SH_HGR2]
        && !(aux && SHADOW[SH_AUX]))
      hit = 1'b1;
    if (aux && in_rng(addr, SHR_LO, SHR_HI) && !SHADOW[SH_SHR])
      hit = 1'b1;
  end

  assign push  = fast_clk & we & bank_ok & hit;
  assign pop   = slow_ce & ~empty;
  assign entry = '{bank0: aux, addr: addr, data: dout};

  shadow_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (entry),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      shadow_we   <= 1'b0;
      shadow_addr <= '0;
      shadow_data <= '0;
      cpu_stall   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      shadow_we <= pop;
      if (pop) begin
        shadow_addr <= {head.bank0, head.addr};
        shadow_data <= head.data;
      end
      cpu_stall <= (count >= CW'(DEPTH - 1));
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shadow_writer.sv
// Randomized and directed check of shadow_writer against a queue model.
// Replayed writes are logged for literal ordering checks.
module tb_shadow_writer;

  localparam int DEPTH = 4;

  logic        clk_sys;
  logic        reset_n;
  logic        fast_clk;
  logic [7:0]  bank;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic [7:0]  SHADOW;
  logic        slow_ce;
  logic [16:0] shadow_addr;
  logic [7:0]  shadow_data;
  logic        shadow_we;
  logic        cpu_stall;
  logic        overflow;

  shadow_writer #(.DEPTH(DEPTH)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .fast_clk    (fast_clk),
    .bank        (bank),
    .addr        (addr),
    .dout        (dout),
    .we          (we),
    .SHADOW      (SHADOW),
    .slow_ce     (slow_ce),
    .shadow_addr (shadow_addr),
    .shadow_data (shadow_data),
    .shadow_we   (shadow_we),
    .cpu_stall   (cpu_stall),
    .overflow    (overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural reference: region rules from the memory map.
  function automatic bit model_hit(bit [7:0] b, bit [15:0] a,
                                   bit [7:0] sh);
    bit x;
    if (b > 8'h01) return 1'b0;
    x = (b == 8'h01);
    if (a >= 16'h0400 && a <= 16'h07FF && !sh[0]) return 1'b1;
    if (a >= 16'h0800 && a <= 16'h0BFF && !sh[5]) return 1'b1;
    if (a >= 16'h2000 && a <= 16'h3FFF && !sh[1] && !(x && sh[4]))
      return 1'b1;
    if (a >= 16'h4000 && a <= 16'h5FFF && !sh[2] && !(x && sh[4]))
      return 1'b1;
    if (x && a >= 16'h2000 && a <= 16'h9FFF && !sh[3]) return 1'b1;
    return 1'b0;
  endfunction

  bit [24:0] q[$];
  bit [24:0] wlog[$];
  bit        m_we, m_stall, m_ovf;
  bit [16:0] m_sa;
  bit [7:0]  m_sd;

  always begin
    bit s_rst, s_fc, s_w, s_ce, pop, push;
    bit [7:0] s_b, s_d, s_sh;
    bit [15:0] s_a;
    bit [24:0] e;
    @(posedge clk_sys);
    s_rst = reset_n; s_fc = fast_clk; s_w = we; s_ce = slow_ce;
    s_b = bank; s_a = addr; s_d = dout; s_sh = SHADOW;
    #1;
    if (!s_rst) begin
      q.delete();
      m_we = 0; m_sa = 0; m_sd = 0; m_stall = 0; m_ovf = 0;
    end else begin
      m_stall = (q.size() >= DEPTH - 1);
      pop  = s_ce && (q.size() > 0);
      push = s_fc && s_w && model_hit(s_b, s_a, s_sh);
      m_we = pop;
      if (pop) begin
        e = q.pop_front();
        m_sa = e[24:8];
        m_sd = e[7:0];
      end
      if (push) begin
        if (q.size() < DEPTH) q.push_back({s_b[0], s_a, s_d});
        else m_ovf = 1;
      end
    end
    chk("shadow_we", shadow_we, m_we);
    chk("shadow_addr", shadow_addr, m_sa);
    chk("shadow_data", shadow_data, m_sd);
    chk("cpu_stall", cpu_stall, m_stall);
    chk("overflow", overflow, m_ovf);
    chk("count", dut.u_fifo.count, q.size());
    if (shadow_we) wlog.push_back({shadow_addr, shadow_data});
  end

  bit       rst_v;
  bit [7:0] sh;

  task automatic drive(bit fc, bit [7:0] b, bit [15:0] a, bit [7:0] d,
                       bit w, bit ce);
    @(negedge clk_sys);
    reset_n = rst_v; SHADOW = sh;
    fast_clk = fc; bank = b; addr = a; dout = d; we = w; slow_ce = ce;
  endtask

  task automatic wr(bit [7:0] b, bit [15:0] a, bit [7:0] d);
    drive(1, b, a, d, 1, 0);
  endtask

  task automatic idle(int n, int period);
    for (int i = 0; i < n; i++)
      drive(0, 8'h00, 16'h0000, 8'h00, 0,
            period != 0 && (i % period) == period - 1);
  endtask

  task automatic do_reset();
    rst_v = 0;
    idle(2, 0);
    rst_v = 1;
    idle(1, 0);
  endtask

  initial begin
    reset_n = 0; fast_clk = 0; bank = 0; addr = 0; dout = 0;
    we = 0; SHADOW = 0; slow_ce = 0;
    rst_v = 0; sh = 8'h00;

    do_reset();
    @(negedge clk_sys);
    chk("rst_we", shadow_we, 0);
    chk("rst_addr", shadow_addr, 0);
    chk("rst_data", shadow_data, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ovf", overflow, 0);

    // TXT1 write replayed on the periodic slow slot
    wlog.delete();
    sh = 8'h00;
    wr(8'h00, 16'h0400, 8'h41);
    idle(30, 14);
    chk("txt1_n", wlog.size(), 1);
    if (wlog.size() >= 1) chk("txt1_e", wlog[0], 25'h0040041);

    // SHR with aux inhibit, then SHR inhibited too
    wlog.delete();
    sh = 8'h10;
    wr(8'h01, 16'h2000, 8'hAA);
    sh = 8'h18;
    wr(8'h01, 16'h2000, 8'hBB);
    idle(8, 1);
    chk("shr_n", wlog.size(), 1);
    if (wlog.size() >= 1) chk("shr_e", wlog[0], 25'h12000AA);

    // TXT1 inhibited, TXT2 still shadowed
    wlog.delete();
    sh = 8'h01;
    wr(8'h00, 16'h0400, 8'h11);
    wr(8'h00, 16'h0800, 8'h55);
    idle(8, 1);
    chk("txt2_n", wlog.size(), 1);
    if (wlog.size() >= 1) chk("txt2_e", wlog[0], 25'h0080055);

    // Fill with slow_ce low: stall, then overflow, then ordered drain
    wlog.delete();
    sh = 8'h00;
    for (int i = 0; i < 5; i++) begin
      wr(8'h00, 16'h0400 + 16'(i), 8'(i));
      idle(2, 0);
      if (i == 1) chk("stall_lo", cpu_stall, 0);
      if (i == 2) chk("stall_hi", cpu_stall, 1);
      if (i == 3) chk("ovf_lo", overflow, 0);
    end
    chk("ovf_hi", overflow, 1);
    idle(10, 1);
    chk("drain_n", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size())
        chk("drain_e", wlog[i], {1'b0, 16'h0400 + 16'(i), 8'(i)});

    // Push and pop on a full FIFO in the same cycle
    do_reset();
    wlog.delete();
    for (int i = 0; i < 4; i++) wr(8'h01, 16'h4000 + 16'(i), 8'h10 + 8'(i));
    idle(1, 0);
    drive(1, 8'h01, 16'h4004, 8'h14, 1, 1);
    idle(1, 0);
    chk("pp_ovf", overflow, 0);
    chk("pp_count", dut.u_fifo.count, 4);
    idle(10, 1);
    chk("pp_n", wlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size())
        chk("pp_e", wlog[i], {1'b1, 16'h4000 + 16'(i), 8'h10 + 8'(i)});

    // Reset discards pending entries
    wlog.delete();
    for (int i = 0; i < 3; i++) wr(8'h00, 16'h0800 + 16'(i), 8'(i));
    idle(1, 0);
    rst_v = 0;
    idle(2, 1);
    rst_v = 1;
    idle(10, 1);
    chk("rst_pend_n", wlog.size(), 0);
    chk("rst_pend_stall", cpu_stall, 0);
    chk("rst_pend_ovf", overflow, 0);

    // Randomized traffic with varying drain rates
    for (int p = 0; p < 6; p++) begin
      int ce_div;
      ce_div = 1 + p * 3;
      for (int i = 0; i < 600; i++) begin
        bit [7:0] b;
        bit [15:0] a;
        case ($urandom_range(0, 3))
          0: b = 8'h00;
          1: b = 8'h01;
          2: b = 8'hE0;
          default: b = 8'($urandom);
        endcase
        a = 16'($urandom_range(0, 16'hBFFF));
        if ($urandom_range(0, 15) == 0) sh = 8'($urandom);
        rst_v = ($urandom_range(0, 299) != 0);
        drive($urandom_range(0, 2) == 0, b, a, 8'($urandom),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, ce_div - 1) == 0);
      end
    end
    rst_v = 1;
    idle(4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
